// File: rtl/button_debouncer.sv
// Multi-channel button conditioner: 2-FF sync, debounce, press/release strobes.
// Define BTN_LONGPRESS_EN to add a per-channel one-shot long-press strobe.
module button_debouncer #(
  parameter int   SYS_CLK_FREQ = 30_000_000,
  parameter int   DEBOUNCE_MS  = 10,
  parameter int   LONG_MS      = 1000,
  parameter int   CHANNELS     = 4,
  parameter logic ACTIVE_LEVEL = 1'b0
) (
  input  logic                sysclk,
  input  logic                resetn,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_state,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_long
);

  localparam int DEBOUNCE_CYCLES = SYS_CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || LONG_MS < 0) begin : g_cfg_check
    $error("button_debouncer: invalid timing parameters");
  end

  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;
  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] state_q, state_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] rel_q, rel_d;
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];

  assign raw = ~(sync2_q ^ {CHANNELS{ACTIVE_LEVEL}});

  always_comb begin
    state_d = state_q;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (raw[i] != state_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          state_d[i] = raw[i];
          press_d[i] = raw[i];
          rel_d[i]   = ~raw[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (!resetn) begin
      sync1_q <= {CHANNELS{~ACTIVE_LEVEL}};
      sync2_q <= {CHANNELS{~ACTIVE_LEVEL}};
      state_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_state   = state_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;

`ifdef BTN_LONGPRESS_EN
  localparam int LONG_CYCLES = SYS_CLK_FREQ / 1000 * LONG_MS;
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] HOLD_MAX = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] HOLD_PRE = LW'(LONG_CYCLES - 1);

  logic [LW-1:0]       hold_q [CHANNELS];
  logic [LW-1:0]       hold_d [CHANNELS];
  logic [CHANNELS-1:0] long_q, long_d;

  // Hold counter parks at HOLD_MAX so the strobe fires once per press.
  always_comb begin
    long_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hold_d[i] = '0;
      if (state_q[i]) begin
        hold_d[i] = hold_q[i];
        if (hold_q[i] != HOLD_MAX) begin
          hold_d[i] = hold_q[i] + 1'b1;
          long_d[i] = (hold_q[i] == HOLD_PRE);
        end
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (!resetn) begin
      long_q <= '0;
      for (int i = 0; i < CHANNELS; i++) hold_q[i] <= '0;
    end else begin
      long_q <= long_d;
      for (int i = 0; i < CHANNELS; i++) hold_q[i] <= hold_d[i];
    end
  end

  assign btn_long = long_q;
`else
  assign btn_long = '0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: stimulus queues expected events,
// a negedge monitor pops and checks whenever an output strobes or changes.
module tb_button_debouncer;

  logic       sysclk = 1'b0;
  logic       resetn;
  logic [3:0] btn_in;
  logic [3:0] btn_state, btn_press, btn_release, btn_long;

  button_debouncer #(
    .SYS_CLK_FREQ(4000),
    .DEBOUNCE_MS (1),
    .LONG_MS     (5),
    .CHANNELS    (4),
    .ACTIVE_LEVEL(1'b0)
  ) dut (
    .sysclk     (sysclk),
    .resetn     (resetn),
    .btn_in     (btn_in),
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int         cyc;
    logic [3:0] st;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] lg;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  bit         mon_en = 0;
  logic [3:0] prev_state = '0;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic expect_ev(input int c, input logic [3:0] st,
                           input logic [3:0] pr, input logic [3:0] rl,
                           input logic [3:0] lg);
    exp_t x;
    x.cyc = c;
    x.st  = st;
    x.pr  = pr;
    x.rl  = rl;
    x.lg  = lg;
    exp_q.push_back(x);
  endtask

  always @(negedge sysclk) begin
    if (mon_en && (|btn_press || |btn_release || |btn_long ||
                   btn_state != prev_state)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event cyc=%0d state=%b press=%b rel=%b long=%b",
                 cyc, btn_state, btn_press, btn_release, btn_long);
      end else begin
        e = exp_q.pop_front();
        tests++;
        if (cyc != e.cyc) begin
          fails++;
          $display("FAIL event_cycle got=%0d exp=%0d", cyc, e.cyc);
        end
        tests++;
        if ({btn_state, btn_press, btn_release, btn_long} !==
            {e.st, e.pr, e.rl, e.lg}) begin
          fails++;
          $display("FAIL event_outputs cyc=%0d got st/pr/rl/lg=%b/%b/%b/%b exp=%b/%b/%b/%b",
                   cyc, btn_state, btn_press, btn_release, btn_long,
                   e.st, e.pr, e.rl, e.lg);
        end
      end
    end
    prev_state = btn_state;
  end

  task automatic chk_rst(input string name, input logic [3:0] got);
    tests++;
    if (got !== 4'b0000) begin
      fails++;
      $display("FAIL %s got=%b exp=0000", name, got);
    end
  endtask

  initial begin
    int t;
    resetn = 1'b0;
    btn_in = 4'hF;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    chk_rst("reset_state", btn_state);
    chk_rst("reset_press", btn_press);
    chk_rst("reset_release", btn_release);
    chk_rst("reset_long", btn_long);
    prev_state = btn_state;
    mon_en = 1;
    @(posedge sysclk);
    #1 resetn = 1'b1;
    wait_cyc(3);

    // clean press on channel 0, then release
    btn_in[0] = 1'b0;
    expect_ev(cyc + 6, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    wait_cyc(10);
    btn_in[0] = 1'b1;
    expect_ev(cyc + 6, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    wait_cyc(10);

    // glitches of 3 cycles on channel 1: nothing expected
    for (int k = 0; k < 5; k++) begin
      btn_in[1] = 1'b0;
      wait_cyc(3);
      btn_in[1] = 1'b1;
      wait_cyc(3);
    end
    wait_cyc(10);

    // bounce on channel 2, settle low, then release
    for (int k = 0; k < 5; k++) begin
      btn_in[2] = ~btn_in[2];
      if (k < 4) wait_cyc(2);
    end
    expect_ev(cyc + 6, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    wait_cyc(10);
    btn_in[2] = 1'b1;
    expect_ev(cyc + 6, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    wait_cyc(10);

    // all channels together
    btn_in = 4'h0;
    expect_ev(cyc + 6, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    wait_cyc(10);
    btn_in = 4'hF;
    expect_ev(cyc + 6, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    wait_cyc(10);

    // reset while channel 0 is held pressed
    btn_in[0] = 1'b0;
    expect_ev(cyc + 6, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    wait_cyc(8);
    resetn = 1'b0;
    expect_ev(cyc + 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    wait_cyc(1);
    resetn = 1'b1;
    expect_ev(cyc + 6, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    wait_cyc(10);
    btn_in[0] = 1'b1;
    expect_ev(cyc + 6, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    wait_cyc(10);

    // long hold on channel 0
    btn_in[0] = 1'b0;
    t = cyc;
    expect_ev(t + 6, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
`ifdef BTN_LONGPRESS_EN
    expect_ev(t + 26, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
`endif
    wait_cyc(40);
    btn_in[0] = 1'b1;
    expect_ev(cyc + 6, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    wait_cyc(12);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_events got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
